// File: rtl/calc_pkg.sv
// Shared calculator datapath types: FSM state encoding, default widths,
// and limb-count / index-width helpers for the multi-cycle units.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_BITS  = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int calc_limbs(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index register width; a single-limb build still needs one bit.
  function automatic int calc_idx_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit subtract with borrow in/out; one limb of the
// wide subtractor's borrow chain.
module sub_chunk
  import calc_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             borrow_in,
  output logic [CHUNK-1:0] diff,
  output logic             borrow_out
);

  logic [CHUNK:0] full_s;

  // A negative limb result wraps into the extra top bit, which is the borrow.
  assign full_s     = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
  assign diff       = full_s[CHUNK-1:0];
  assign borrow_out = full_s[CHUNK];

endmodule

// File: rtl/wide_sub_seq.sv
// Multi-cycle wide subtractor, one CHUNK-bit limb per clock with start/done.
// Optional saturation on error when WIDE_SUB_SAT_EN is defined.
module wide_sub_seq
  import calc_pkg::*;
#(
  parameter int bits  = DEF_BITS,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [bits-1:0] a,
  input  logic [bits-1:0] b,
  input  logic            signed_mode,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] out,
  output logic            sub_err
);

  localparam int N     = calc_limbs(bits, CHUNK);
  localparam int IDX_W = calc_idx_w(bits, CHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((bits <= 0) || (CHUNK <= 0) || ((bits % CHUNK) != 0)) begin : g_bad_cfg
    $error("wide_sub_seq: bits must be a positive multiple of CHUNK");
  end

  state_t           state_r;
  logic [bits-1:0]  a_r;
  logic [bits-1:0]  b_r;
  logic             signed_r;
  logic             borrow_r;
  logic [IDX_W-1:0] idx_r;
  logic [bits-1:0]  res_r;
  logic             busy_r;
  logic             done_r;
  logic [bits-1:0]  out_r;
  logic             err_r;

  logic [CHUNK-1:0] a_limb_s;
  logic [CHUNK-1:0] b_limb_s;
  logic [CHUNK-1:0] diff_s;
  logic             borrow_out_s;
  logic [bits-1:0]  wrapped_s;
  logic [bits-1:0]  result_s;
  logic             err_s;

  assign a_limb_s = a_r[idx_r*CHUNK +: CHUNK];
  assign b_limb_s = b_r[idx_r*CHUNK +: CHUNK];

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .a          (a_limb_s),
    .b          (b_limb_s),
    .borrow_in  (borrow_r),
    .diff       (diff_s),
    .borrow_out (borrow_out_s)
  );

  // Result as it stands once the current limb is merged, plus error and final value.
  always_comb begin
    wrapped_s = res_r;
    wrapped_s[idx_r*CHUNK +: CHUNK] = diff_s;
    if (signed_r) begin
      err_s = (a_r[bits-1] != b_r[bits-1]) && (wrapped_s[bits-1] != a_r[bits-1]);
    end else begin
      err_s = borrow_out_s;
    end
`ifdef WIDE_SUB_SAT_EN
    if (err_s) begin
      if (signed_r) begin
        result_s = a_r[bits-1] ? {1'b1, {(bits-1){1'b0}}} : {1'b0, {(bits-1){1'b1}}};
      end else begin
        result_s = '0;
      end
    end else begin
      result_s = wrapped_s;
    end
`else
    result_s = wrapped_s;
`endif
  end

  // Sequencer: capture in IDLE, one limb per edge in RUN, one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      signed_r <= 1'b0;
      borrow_r <= 1'b0;
      idx_r    <= '0;
      res_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      out_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            signed_r <= signed_mode;
            borrow_r <= 1'b0;
            idx_r    <= '0;
            res_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          res_r    <= wrapped_s;
          borrow_r <= borrow_out_s;
          if (idx_r == LAST_IDX) begin
            out_r   <= result_s;
            err_r   <= err_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign out     = out_r;
  assign sub_err = err_r;

endmodule

// File: tb/tb_wide_sub_seq.sv
// Scoreboard bench for wide_sub_seq: a 32/8 instance and a 12/4 instance.
module tb_wide_sub_seq;

`ifdef WIDE_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] o;
    logic        e;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q32[$];
  exp_t        q12[$];

  logic        start32 = 1'b0, sm32 = 1'b0, busy32, done32, err32;
  logic [31:0] a32 = '0, b32 = '0, out32;
  logic        start12 = 1'b0, sm12 = 1'b0, busy12, done12, err12;
  logic [11:0] a12 = '0, b12 = '0, out12;

  wide_sub_seq #(.bits(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
    .signed_mode(sm32), .busy(busy32), .done(done32), .out(out32), .sub_err(err32)
  );

  wide_sub_seq #(.bits(12), .CHUNK(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .a(a12), .b(b12),
    .signed_mode(sm12), .busy(busy12), .done(done12), .out(out12), .sub_err(err12)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL done32_unexpected: got done with empty scoreboard (t=%0t)", $time);
      end else begin
        exp_t x;
        x = q32.pop_front();
        chk("out32", out32, x.o);
        chk("err32", {31'd0, err32}, {31'd0, x.e});
        chk("lat32", cyc, x.c);
        chk("busy_at_done32", {31'd0, busy32}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done12) begin
      if (q12.size() == 0) begin
        checks++; errors++;
        $display("FAIL done12_unexpected: got done with empty scoreboard (t=%0t)", $time);
      end else begin
        exp_t x;
        x = q12.pop_front();
        chk("out12", {20'd0, out12}, x.o);
        chk("err12", {31'd0, err12}, {31'd0, x.e});
        chk("lat12", cyc, x.c);
      end
    end
  end

  task automatic wait_idle32();
    for (int i = 0; i < 40 && busy32; i++) @(negedge clk);
    if (busy32) begin
      errors++;
      $display("FAIL idle32_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic wait_idle12();
    for (int i = 0; i < 40 && busy12; i++) @(negedge clk);
    if (busy12) begin
      errors++;
      $display("FAIL idle12_timeout: got busy=1 expected 0");
    end
  endtask

  // Issue one operation at a negedge; done is due N+1 edges later counting the accept edge.
  task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic sm,
                      input logic [31:0] eo, input logic ee);
    wait_idle32();
    start32 = 1'b1; a32 = av; b32 = bv; sm32 = sm;
    q32.push_back('{o: eo, e: ee, c: cyc + 5});
    @(negedge clk);
    start32 = 1'b0; a32 = ~av; b32 = ~bv; sm32 = ~sm;
    chk("busy_after_start32", {31'd0, busy32}, 32'd1);
  endtask

  task automatic op12(input logic [11:0] av, input logic [11:0] bv, input logic sm,
                      input logic [11:0] eo, input logic ee);
    wait_idle12();
    start12 = 1'b1; a12 = av; b12 = bv; sm12 = sm;
    q12.push_back('{o: {20'd0, eo}, e: ee, c: cyc + 4});
    @(negedge clk);
    start12 = 1'b0; a12 = ~av; b12 = ~bv; sm12 = ~sm;
    chk("busy_after_start12", {31'd0, busy12}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    #12;
    chk("rst_busy32", {31'd0, busy32}, 32'd0);
    chk("rst_done32", {31'd0, done32}, 32'd0);
    chk("rst_out32", out32, 32'd0);
    chk("rst_err32", {31'd0, err32}, 32'd0);
    chk("rst_busy12", {31'd0, busy12}, 32'd0);
    chk("rst_out12", {20'd0, out12}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op32(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0);
    op32(32'd5, 32'd7, 1'b0, SAT ? 32'h0000_0000 : 32'hFFFF_FFFE, 1'b1);
    op32(32'h8000_0000, 32'd1, 1'b1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1);
    op32(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 32'h0000_0002, 1'b0);
    op32(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0);
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);
    op32(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0);
    op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0);

    op12(12'h100, 12'h001, 1'b0, 12'h0FF, 1'b0);
    op12(12'h005, 12'h007, 1'b0, SAT ? 12'h000 : 12'hFFE, 1'b1);

    // Starts during RUN and coincident with done must be dropped.
    op32(32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_0FFF, 1'b0);
    @(negedge clk);
    start32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 0; i < 10 && !done32; i++) @(negedge clk);
    chk("done_seen32", {31'd0, done32}, 32'd1);
    start32 = 1'b1; a32 = 32'hAAAA_AAAA; b32 = 32'h1111_1111;
    @(negedge clk);
    start32 = 1'b0;
    chk("start_at_done_ignored", {31'd0, busy32}, 32'd0);
    op32(32'h5555_5555, 32'h1111_1111, 1'b0, 32'h4444_4444, 1'b0);

    // Reset mid-RUN after two limbs: everything clears, no done follows.
    op32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1);
    op32(32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q32.delete();
    #1;
    chk("midrst_busy32", {31'd0, busy32}, 32'd0);
    chk("midrst_done32", {31'd0, done32}, 32'd0);
    chk("midrst_out32", out32, 32'd0);
    chk("midrst_err32", {31'd0, err32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done32) seen++;
    end
    chk("no_done_after_rst", seen, 32'd0);
    op32(32'h0000_0010, 32'h0000_0003, 1'b0, 32'h0000_000D, 1'b0);

    for (int i = 0; i < 40 && (q32.size() != 0 || q12.size() != 0); i++) @(negedge clk);
    chk("q32_drained", q32.size(), 32'd0);
    chk("q12_drained", q12.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
